perc_voice: RTL and testbench



---
 rtl/perc_voice.sv | 157 +++++++++++++++
 tb/tb_perc_voice.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/perc_voice.sv
// Percussion voice: swept triangle oscillator plus LFSR noise, each with its own
// exponential decay envelope, computing one sample per start/finish handshake.
module perc_voice #(
   parameter int          W         = 24,
   parameter int          PHASE_W   = 24,
   parameter int          MULT_LAT  = 2,
   parameter logic [31:0] SEED      = 32'h1701D6F0,
   parameter logic [23:0] AMP_FLOOR = 24'd8388
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic               finish,
   input  logic [63:0]        mult_p,
   output logic [31:0]        mult_a,
   output logic [31:0]        mult_b,
   input  logic               trigger,
   input  logic               choke,
   input  logic [7:0]         velocity,
   input  logic [1:0]         mode,
   input  logic [PHASE_W-1:0] freq_start,
   input  logic [PHASE_W-1:0] freq_end,
   input  logic [PHASE_W-1:0] freq_step,
   input  logic [23:0]        tone_decay,
   input  logic [23:0]        noise_decay,
   output logic [W-1:0]       wave_out
);

   typedef enum logic [2:0] {
      IDLE, ENV_TONE, ENV_NOISE, OSC, MIX_TONE, MIX_NOISE, FINISH
   } state_t;

   localparam int               CNT_W    = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULT_LAT - 1);
   localparam logic [31:0]      TAPS     = 32'h80200003;

   state_t             state, state_next;
   logic [CNT_W-1:0]   cnt;
   logic               cnt_done, mul_state;
   logic [23:0]        amp_tone, amp_noise;
   logic [PHASE_W-1:0] phase, freq_cur, freq_dec;
   logic [PHASE_W:0]   freq_diff;
   logic [31:0]        lfsr, lfsr_next;
   logic [63:0]        mix, mix_sum;
   logic [PHASE_W+23:0] phase_ext;
   logic [22:0]        t_hi;
   logic [23:0]        tri_u, tri_val, noise;
   logic               unused_bits;

   assign cnt_done = (cnt == CNT_LAST);
   assign finish   = (state == FINISH);

   // Narrow phase widths are zero-padded below so the 24-bit triangle slice always exists.
   assign phase_ext = {phase, 24'd0};
   assign t_hi      = phase_ext[PHASE_W+22 -: 23];
   assign tri_u     = phase[PHASE_W-1] ? {1'b0, ~t_hi} : {1'b0, t_hi};
   assign tri_val   = (tri_u - 24'h400000) << 1;
   assign noise     = lfsr[31:8];

   assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);

   // Sweep subtraction carries an extra borrow bit so an underflow clamps instead of wrapping.
   assign freq_diff = {1'b0, freq_cur} - {1'b0, freq_step};
   assign freq_dec  = (!freq_diff[PHASE_W] && (freq_diff[PHASE_W-1:0] > freq_end))
                      ? freq_diff[PHASE_W-1:0] : freq_end;

   assign mix_sum     = mix + (mode[0] ? 64'd0 : mult_p);
   assign unused_bits = ^{mix, phase_ext};

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      mult_a     = '0;
      mult_b     = '0;
      mul_state  = 1'b0;
      case (state)
         IDLE:      if (start) state_next = trigger ? OSC : ENV_TONE;
         ENV_TONE: begin
            mul_state = 1'b1;
            mult_a    = {8'd0, tone_decay};
            mult_b    = {8'd0, amp_tone};
            if (cnt_done) state_next = ENV_NOISE;
         end
         ENV_NOISE: begin
            mul_state = 1'b1;
            mult_a    = {8'd0, noise_decay};
            mult_b    = {8'd0, amp_noise};
            if (cnt_done) state_next = OSC;
         end
         OSC:       state_next = MIX_TONE;
         MIX_TONE: begin
            mul_state = 1'b1;
            mult_a    = {{8{tri_val[23]}}, tri_val};
            mult_b    = {8'd0, amp_tone};
            if (cnt_done) state_next = MIX_NOISE;
         end
         MIX_NOISE: begin
            mul_state = 1'b1;
            mult_a    = {{8{noise[23]}}, noise};
            mult_b    = {8'd0, amp_noise};
            if (cnt_done) state_next = FINISH;
         end
         FINISH:    state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         amp_tone  <= '0;
         amp_noise <= '0;
         phase     <= '0;
         freq_cur  <= '0;
         lfsr      <= SEED;
         mix       <= '0;
         wave_out  <= '0;
      end else begin
         cnt <= (mul_state && !cnt_done) ? cnt + 1'b1 : '0;
         case (state)
            IDLE: begin
               if (start && trigger) begin
                  amp_tone  <= {velocity, 16'h0};
                  amp_noise <= {velocity, 16'h0};
                  freq_cur  <= freq_start;
                  phase     <= '0;
               end else if (start) begin
                  if (choke) begin
                     amp_tone  <= '0;
                     amp_noise <= '0;
                  end
                  freq_cur <= freq_dec;
               end
            end
            ENV_TONE:  if (cnt_done) amp_tone  <= (amp_tone  < AMP_FLOOR) ? '0 : mult_p[47:24];
            ENV_NOISE: if (cnt_done) amp_noise <= (amp_noise < AMP_FLOOR) ? '0 : mult_p[47:24];
            OSC: begin
               phase <= phase + freq_cur;
               lfsr  <= lfsr_next;
            end
            MIX_TONE:  if (cnt_done) mix <= mode[1] ? 64'd0 : mult_p;
            MIX_NOISE: begin
               if (cnt_done) begin
                  mix      <= mix_sum;
                  wave_out <= mix_sum[48 -: W];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_perc_voice.sv
// Self-checking bench for perc_voice: a behavioural voice model pushes expected
// results per start, and they are popped and compared when finish pulses.
module tb_perc_voice;

   localparam int          L    = 2;
   localparam logic [31:0] SEED = 32'h1701D6F0;
   localparam logic [31:0] TAPS = 32'h80200003;

   logic        clk = 1'b0;
   logic        rst, start, trigger, choke, finish;
   logic [7:0]  velocity;
   logic [1:0]  mode;
   logic [23:0] freq_start, freq_end, freq_step, tone_decay, noise_decay;
   logic [63:0] mult_p;
   logic [31:0] mult_a, mult_b;
   logic [23:0] wave_out;

   int checkCount = 0;
   int errorCount = 0;

   typedef struct {
      logic [23:0] wave, ampT, ampN, freq, phase;
      logic [31:0] lfsr;
      int          lat;
   } exp_t;

   exp_t        sbq[$];
   logic [23:0] mAmpT, mAmpN, mFreq, mPhase;
   logic [31:0] mLfsr;

   perc_voice #(.W(24), .PHASE_W(24), .MULT_LAT(L), .SEED(SEED), .AMP_FLOOR(24'd8388)) dut (
      .clk(clk), .rst(rst), .start(start), .finish(finish),
      .mult_p(mult_p), .mult_a(mult_a), .mult_b(mult_b),
      .trigger(trigger), .choke(choke), .velocity(velocity), .mode(mode),
      .freq_start(freq_start), .freq_end(freq_end), .freq_step(freq_step),
      .tone_decay(tone_decay), .noise_decay(noise_decay), .wave_out(wave_out)
   );

   always #5 clk = ~clk;

   // Shared multiplier with one register stage, so products are ready on the
   // second cycle of each operand hold.
   always @(posedge clk)
      mult_p <= {{32{mult_a[31]}}, mult_a} * {{32{mult_b[31]}}, mult_b};

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checkCount++;
      if (got !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [23:0] envModel(input logic [23:0] amp, input logic [23:0] coef);
      longint unsigned p;
      if (amp < 24'd8388) return 24'd0;
      p = longint'(coef) * longint'(amp);
      return p[47:24];
   endfunction

   task automatic modelReset();
      mAmpT  = '0;
      mAmpN  = '0;
      mFreq  = '0;
      mPhase = '0;
      mLfsr  = SEED;
   endtask

   task automatic modelSample(input bit trig, input bit chk, input logic [7:0] vel,
                              input logic [1:0] md, output exp_t e);
      longint      triI, noiseI, mixv;
      logic [23:0] triU;
      logic [63:0] mixBits;
      if (trig) begin
         mAmpT  = {vel, 16'h0};
         mAmpN  = {vel, 16'h0};
         mFreq  = freq_start;
         mPhase = '0;
         e.lat  = 2 * L + 2;
      end else begin
         if (chk) begin
            mAmpT = '0;
            mAmpN = '0;
         end
         if (mFreq > freq_step && (mFreq - freq_step) > freq_end) mFreq = mFreq - freq_step;
         else mFreq = freq_end;
         mAmpT = envModel(mAmpT, tone_decay);
         mAmpN = envModel(mAmpN, noise_decay);
         e.lat = 4 * L + 2;
      end
      mPhase = mPhase + mFreq;
      mLfsr  = mLfsr[0] ? ((mLfsr >> 1) ^ TAPS) : (mLfsr >> 1);
      triU   = mPhase[23] ? {1'b0, ~mPhase[22:0]} : {1'b0, mPhase[22:0]};
      triI   = longint'(triU);
      triI   = (triI - 4194304) * 2;
      noiseI = longint'($signed(mLfsr[31:8]));
      mixv   = 0;
      if (!md[1]) mixv = triI * longint'(mAmpT);
      if (!md[0]) mixv = mixv + noiseI * longint'(mAmpN);
      mixBits = mixv;
      e.wave  = mixBits[48:25];
      e.ampT  = mAmpT;
      e.ampN  = mAmpN;
      e.freq  = mFreq;
      e.phase = mPhase;
      e.lfsr  = mLfsr;
   endtask

   task automatic applyStimulus(input bit trig, input bit chk, input logic [7:0] vel,
                                input logic [1:0] md, input bit injectStart);
      exp_t e, want;
      int   cyc;
      @(negedge clk);
      trigger  = trig;
      choke    = chk;
      velocity = vel;
      mode     = md;
      start    = 1'b1;
      modelSample(trig, chk, vel, md, e);
      sbq.push_back(e);
      @(posedge clk);
      #1;
      start   = 1'b0;
      trigger = 1'b0;
      choke   = 1'b0;
      cyc     = 1;
      while (finish !== 1'b1 && cyc < 40) begin
         @(posedge clk);
         #1;
         cyc++;
         start   = injectStart && (cyc == 2);
         trigger = injectStart && (cyc == 2);
      end
      start   = 1'b0;
      trigger = 1'b0;
      want = sbq.pop_front();
      checkOutput("latency", cyc, want.lat);
      checkOutput("wave_out", wave_out, want.wave);
      checkOutput("amp_tone", dut.amp_tone, want.ampT);
      checkOutput("amp_noise", dut.amp_noise, want.ampN);
      checkOutput("freq_cur", dut.freq_cur, want.freq);
      checkOutput("phase", dut.phase, want.phase);
      checkOutput("lfsr", dut.lfsr, want.lfsr);
      @(posedge clk);
      #1;
      checkOutput("finish_one_cycle", finish, 1'b0);
   endtask

   task automatic resetMidMix();
      exp_t e;
      int   pulses = 0;
      @(negedge clk);
      start = 1'b1;
      modelSample(1'b0, 1'b0, velocity, mode, e);
      sbq.push_back(e);
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      checkOutput("in_mix_tone", dut.state, 64'd4);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      sbq.delete();
      modelReset();
      repeat (15) begin
         if (finish === 1'b1) pulses++;
         @(posedge clk);
         #1;
      end
      checkOutput("abort_no_finish", pulses, 0);
      checkOutput("abort_lfsr_seed", dut.lfsr, SEED);
      checkOutput("abort_amp_tone", dut.amp_tone, 24'd0);
      checkOutput("abort_wave", wave_out, 24'd0);
   endtask

   initial begin
      logic [23:0] ampSeq [4];
      logic [23:0] freqSeq [4];
      ampSeq[0]  = 24'hFF0000; ampSeq[1]  = 24'h7F8000; ampSeq[2]  = 24'h3FC000; ampSeq[3]  = 24'h1FE000;
      freqSeq[0] = 24'd1000;   freqSeq[1] = 24'd960;    freqSeq[2] = 24'd920;    freqSeq[3] = 24'd900;

      rst = 1'b1; start = 1'b0; trigger = 1'b0; choke = 1'b0;
      velocity = '0; mode = '0;
      freq_start = '0; freq_end = '0; freq_step = '0;
      tone_decay = 24'h800000; noise_decay = 24'hC00000;
      modelReset();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("reset_finish", finish, 1'b0);
      checkOutput("reset_wave", wave_out, 24'd0);
      checkOutput("reset_lfsr", dut.lfsr, SEED);
      checkOutput("reset_amp_tone", dut.amp_tone, 24'd0);
      checkOutput("reset_phase", dut.phase, 24'd0);

      // Normal sample straight after reset: silent output, full latency.
      applyStimulus(1'b0, 1'b0, 8'h00, 2'd0, 1'b0);
      checkOutput("first_wave_zero", wave_out, 24'd0);

      // Trigger with tone only.
      freq_start = 24'h010000;
      applyStimulus(1'b1, 1'b0, 8'h80, 2'd1, 1'b0);
      checkOutput("trig_amp", dut.amp_tone, 24'h800000);
      checkOutput("trig_phase", dut.phase, 24'h010000);

      // Halving envelope and clamped sweep, with a stray start mid-sample.
      freq_start = 24'd1000; freq_end = 24'd900; freq_step = 24'd40;
      applyStimulus(1'b1, 1'b0, 8'hFF, 2'd0, 1'b0);
      checkOutput("seq_amp0", dut.amp_tone, ampSeq[0]);
      checkOutput("seq_freq0", dut.freq_cur, freqSeq[0]);
      for (int i = 1; i < 15; i++) begin
         applyStimulus(1'b0, 1'b0, 8'h00, 2'(i % 4), i == 1);
         if (i < 4) begin
            checkOutput("seq_amp", dut.amp_tone, ampSeq[i]);
            checkOutput("seq_freq", dut.freq_cur, freqSeq[i]);
         end
      end
      checkOutput("amp_floored", dut.amp_tone, 24'd0);

      // Trigger beats choke; choke alone silences the same sample.
      applyStimulus(1'b1, 1'b1, 8'h40, 2'd0, 1'b0);
      checkOutput("choke_trig_amp", dut.amp_noise, 24'h400000);
      applyStimulus(1'b0, 1'b1, 8'h40, 2'd0, 1'b0);
      checkOutput("choke_amp", dut.amp_tone, 24'd0);
      checkOutput("choke_wave", wave_out, 24'd0);

      for (int i = 0; i < 6; i++) begin
         tone_decay  = 24'($urandom_range(24'hFFFFFF, 24'h400000));
         noise_decay = 24'($urandom_range(24'hFFFFFF, 24'h400000));
         freq_start  = 24'($urandom_range(24'h0FFFFF, 24'h001000));
         freq_step   = 24'($urandom_range(24'h00FFFF, 0));
         freq_end    = 24'($urandom_range(24'h000FFF, 0));
         applyStimulus(i % 3 == 0, 1'b0, 8'($urandom_range(255, 1)), 2'($urandom_range(3, 0)), 1'b0);
      end

      resetMidMix();
      applyStimulus(1'b0, 1'b0, 8'h00, 2'd0, 1'b0);
      applyStimulus(1'b1, 1'b0, 8'hC0, 2'd0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
